// File: rtl/mac_pkg.sv
// Shared types and constants for the mac_acc accumulator slice:
// FSM state encoding, default widths and a clog2 helper for sizing.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } mac_state_e;

    localparam int MAC_IN_W      = 16;
    localparam int MAC_NUM_TERMS = 16;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int r;
        int x;
        r = 0;
        x = value - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_acc_if.sv
// Product-in / result-out handshake bundle for mac_acc.
//
// Handshake rule (both channels): a beat transfers on a rising edge where
// valid and ready are both high. The sender keeps valid and data stable
// until that edge; ready never depends combinationally on valid.
interface mac_acc_if
    import mac_pkg::*;
#(
    parameter int IN_W  = MAC_IN_W,
    parameter int ACC_W = MAC_IN_W + clog2(MAC_NUM_TERMS)
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/mac_acc_ctrl.sv
// Control half of mac_acc: IDLE/ACC/HOLD state machine, term counter and
// the handshake/busy flags. Emits one-cycle strobes that tell the
// datapath when to load, add, or publish the finished sum.
module mac_acc_ctrl
    import mac_pkg::*;
#(
    parameter int NUM_TERMS = MAC_NUM_TERMS,
    parameter int CNT_W     = clog2(NUM_TERMS)
)(
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_clr,
    input  logic       i_in_valid,
    input  logic       i_out_ready,
    output logic       o_in_ready,
    output logic       o_out_valid,
    output logic       o_busy,
    output logic       o_load_first,
    output logic       o_add,
    output logic       o_last,
    output mac_state_e o_state
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS - 1);

    mac_state_e       r_state;
    mac_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // State and term counter registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic and datapath strobes; clr overrides everything.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        o_load_first = 1'b0;
        o_add        = 1'b0;
        o_last       = 1'b0;
        if (i_clr) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_in_valid) begin
                        o_load_first = 1'b1;
                        w_cnt_nxt    = CNT_W'(1);
                        w_state_nxt  = ACC;
                    end
                end
                ACC: begin
                    if (i_in_valid) begin
                        o_add = 1'b1;
                        if (r_cnt == LAST_CNT) begin
                            o_last      = 1'b1;
                            w_cnt_nxt   = '0;
                            w_state_nxt = HOLD;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (i_out_ready) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // Handshake flags depend on registered state only.
    assign o_in_ready  = (r_state != HOLD);
    assign o_out_valid = (r_state == HOLD);
    assign o_busy      = (r_cnt != '0);
    assign o_state     = r_state;

endmodule

// File: rtl/mac_acc.sv
// mac_acc: sums NUM_TERMS consecutive unsigned products into one result
// and holds it on a valid/ready output. Control lives in mac_acc_ctrl;
// this file owns the adder and the acc/out_data registers.
// Build option MAC_ACC_SAT_EN: saturating adds plus a sticky 'sat' port;
// without it the sum wraps modulo 2^ACC_W.
module mac_acc
    import mac_pkg::*;
#(
    parameter int IN_W      = MAC_IN_W,
    parameter int NUM_TERMS = MAC_NUM_TERMS,
    parameter int ACC_W     = IN_W + clog2(NUM_TERMS)
)(
    input  logic       clk,
    input  logic       rstn,
    input  logic       clr,
    mac_acc_if.slave   bus,
    output logic       busy,
`ifdef MAC_ACC_SAT_EN
    output logic       sat,
`endif
    output mac_state_e o_dbg_state
);

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_load_first;
    logic             w_add;
    logic             w_last;
    logic [ACC_W-1:0] w_sum;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_out_data;

    mac_acc_ctrl #(
        .NUM_TERMS (NUM_TERMS),
        .CNT_W     (clog2(NUM_TERMS))
    ) u_ctrl (
        .clk          (clk),
        .rstn         (rstn),
        .i_clr        (clr),
        .i_in_valid   (bus.in_valid),
        .i_out_ready  (bus.out_ready),
        .o_in_ready   (w_in_ready),
        .o_out_valid  (w_out_valid),
        .o_busy       (busy),
        .o_load_first (w_load_first),
        .o_add        (w_add),
        .o_last       (w_last),
        .o_state      (o_dbg_state)
    );

`ifdef MAC_ACC_SAT_EN
    logic [ACC_W:0] w_sum_full;
    logic           w_clamp;
    logic           w_handoff;
    logic           r_sat;

    // Widened add so the carry-out flags a clamp.
    always_comb begin
        w_sum_full = {1'b0, r_acc} + (ACC_W + 1)'(bus.in_data);
        w_clamp    = w_sum_full[ACC_W];
        w_sum      = w_clamp ? {ACC_W{1'b1}} : w_sum_full[ACC_W-1:0];
    end

    assign w_handoff = w_out_valid & bus.out_ready;

    // Sticky clamp flag for the result being built; restarts per result.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sat <= 1'b0;
        end else if (clr || w_handoff || w_load_first) begin
            r_sat <= 1'b0;
        end else if (w_add) begin
            r_sat <= r_sat | w_clamp;
        end
    end

    assign sat = r_sat;
`else
    // Plain wrap-around add.
    always_comb begin
        w_sum = r_acc + ACC_W'(bus.in_data);
    end
`endif

    // Accumulator and published result; out_data changes only on completion.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_acc      <= '0;
            r_out_data <= '0;
        end else if (clr) begin
            r_acc <= '0;
        end else if (w_load_first) begin
            r_acc <= ACC_W'(bus.in_data);
        end else if (w_last) begin
            r_out_data <= w_sum;
            r_acc      <= '0;
        end else if (w_add) begin
            r_acc <= w_sum;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_out_data;

endmodule

// File: tb/tb_mac_acc.sv
// Directed bench for mac_acc: default 20-bit instance plus a 17-bit
// instance for the overflow case. Expected values are hand-computed.
module tb_mac_acc;
    import mac_pkg::*;

    logic clk;
    logic rstn;
    logic clr;
    logic busy_main;
    logic busy_17;
    mac_state_e st_main;
    mac_state_e st_17;
`ifdef MAC_ACC_SAT_EN
    logic sat_main;
    logic sat_17;
`endif

    int n_pass;
    int n_total;

    mac_acc_if #(.IN_W(16), .ACC_W(20)) b ();
    mac_acc_if #(.IN_W(16), .ACC_W(17)) c ();

    mac_acc #(.IN_W(16), .NUM_TERMS(16), .ACC_W(20)) u_dut (
        .clk         (clk),
        .rstn        (rstn),
        .clr         (clr),
        .bus         (b),
        .busy        (busy_main),
`ifdef MAC_ACC_SAT_EN
        .sat         (sat_main),
`endif
        .o_dbg_state (st_main)
    );

    mac_acc #(.IN_W(16), .NUM_TERMS(16), .ACC_W(17)) u_dut17 (
        .clk         (clk),
        .rstn        (rstn),
        .clr         (clr),
        .bus         (c),
        .busy        (busy_17),
`ifdef MAC_ACC_SAT_EN
        .sat         (sat_17),
`endif
        .o_dbg_state (st_17)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Back-to-back beats on the main instance: data = base + step*k.
    task automatic beats(input int n, input int base, input int step);
        for (int k = 0; k < n; k++) begin
            b.in_valid = 1'b1;
            b.in_data  = 16'(base + step * k);
            tick();
        end
        b.in_valid = 1'b0;
    endtask

    initial begin
        n_pass      = 0;
        n_total     = 0;
        rstn        = 1'b0;
        clr         = 1'b0;
        b.in_valid  = 1'b0;
        b.in_data   = '0;
        b.out_ready = 1'b0;
        c.in_valid  = 1'b0;
        c.in_data   = '0;
        c.out_ready = 1'b0;

        // Reset values while rstn is low.
        #3;
        check("rst_out_valid", 32'(b.out_valid), 32'd0);
        check("rst_out_data", 32'(b.out_data), 32'd0);
        check("rst_busy", 32'(busy_main), 32'd0);
        check("rst_state", 32'(st_main), 32'(IDLE));
        repeat (4) tick();
        rstn = 1'b1;
        #1;
        check("rst_in_ready", 32'(b.in_ready), 32'd1);

        // Stream 4*i, out_ready high: sum 480, one HOLD cycle.
        b.out_ready = 1'b1;
        b.in_valid  = 1'b1;
        b.in_data   = 16'd0;
        tick();
        check("s1_busy_first", 32'(busy_main), 32'd1);
        beats(15, 4, 4);
        check("s1_out_valid", 32'(b.out_valid), 32'd1);
        check("s1_out_data", 32'(b.out_data), 32'd480);
        check("s1_in_ready_hold", 32'(b.in_ready), 32'd0);
        check("s1_busy_done", 32'(busy_main), 32'd0);
        tick();
        check("s1_out_valid_drop", 32'(b.out_valid), 32'd0);
        check("s1_in_ready_back", 32'(b.in_ready), 32'd1);
        check("s1_out_data_kept", 32'(b.out_data), 32'd480);

        // Backpressure: result held, offered beats not consumed.
        b.out_ready = 1'b0;
        beats(16, 0, 4);
        check("bp_out_valid", 32'(b.out_valid), 32'd1);
        b.in_valid = 1'b1;
        b.in_data  = 16'd7;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_hold_valid", 32'(b.out_valid), 32'd1);
            check("bp_hold_data", 32'(b.out_data), 32'd480);
            check("bp_hold_in_ready", 32'(b.in_ready), 32'd0);
            check("bp_hold_busy", 32'(busy_main), 32'd0);
        end
        b.in_valid  = 1'b0;
        b.out_ready = 1'b1;
        tick();
        check("bp_release", 32'(b.out_valid), 32'd0);
        beats(16, 1, 0);
        check("bp_next_valid", 32'(b.out_valid), 32'd1);
        check("bp_next_data", 32'(b.out_data), 32'd16);
        tick();

        // Gaps: 65025 every other cycle -> 1040400.
        for (int k = 0; k < 16; k++) begin
            b.in_valid = 1'b1;
            b.in_data  = 16'd65025;
            tick();
            b.in_valid = 1'b0;
            if (k < 15) begin
                check("gap_busy_beat", 32'(busy_main), 32'd1);
                tick();
                check("gap_busy_idle", 32'(busy_main), 32'd1);
                check("gap_no_valid", 32'(b.out_valid), 32'd0);
            end
        end
        check("gap_out_valid", 32'(b.out_valid), 32'd1);
        check("gap_out_data", 32'(b.out_data), 32'd1040400);
        check("gap_busy_done", 32'(busy_main), 32'd0);
`ifdef MAC_ACC_SAT_EN
        check("gap_sat", 32'(sat_main), 32'd0);
`endif
        tick();

        // clr mid-sum with a beat offered in the same cycle.
        beats(7, 10, 0);
        check("clr_busy_before", 32'(busy_main), 32'd1);
        clr        = 1'b1;
        b.in_valid = 1'b1;
        b.in_data  = 16'd99;
        tick();
        clr        = 1'b0;
        b.in_valid = 1'b0;
        check("clr_busy", 32'(busy_main), 32'd0);
        check("clr_state", 32'(st_main), 32'(IDLE));
        check("clr_out_valid", 32'(b.out_valid), 32'd0);
        check("clr_out_data_kept", 32'(b.out_data), 32'd1040400);
        beats(16, 1, 0);
        check("clr_next_data", 32'(b.out_data), 32'd16);
        check("clr_next_valid", 32'(b.out_valid), 32'd1);
        tick();

        // Asynchronous reset in ACC with cnt=9.
        beats(9, 5, 0);
        check("ra_busy", 32'(busy_main), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("ra_busy0", 32'(busy_main), 32'd0);
        check("ra_out_data0", 32'(b.out_data), 32'd0);
        check("ra_state", 32'(st_main), 32'(IDLE));
        #2;
        rstn = 1'b1;
        tick();
        beats(16, 2, 0);
        check("ra_next_data", 32'(b.out_data), 32'd32);
        tick();

        // Asynchronous reset in HOLD.
        b.out_ready = 1'b0;
        beats(16, 3, 0);
        check("rh_pre_valid", 32'(b.out_valid), 32'd1);
        check("rh_pre_data", 32'(b.out_data), 32'd48);
        #2;
        rstn = 1'b0;
        #1;
        check("rh_out_valid0", 32'(b.out_valid), 32'd0);
        check("rh_out_data0", 32'(b.out_data), 32'd0);
        check("rh_in_ready", 32'(b.in_ready), 32'd1);
        #2;
        rstn = 1'b1;
        tick();
        b.out_ready = 1'b1;
        beats(16, 0, 4);
        check("rh_next_data", 32'(b.out_data), 32'd480);
        tick();
        check("rh_next_idle", 32'(b.out_valid), 32'd0);

        // Overflow on the 17-bit instance.
        c.out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            c.in_valid = 1'b1;
            c.in_data  = 16'd65025;
            tick();
        end
        c.in_valid = 1'b0;
        check("ov_out_valid", 32'(c.out_valid), 32'd1);
`ifdef MAC_ACC_SAT_EN
        check("ov_out_data", 32'(c.out_data), 32'd131071);
        check("ov_sat", 32'(sat_17), 32'd1);
`else
        check("ov_out_data", 32'(c.out_data), 32'd122896);
`endif
        tick();
        check("ov_idle", 32'(c.out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
